// File: rtl/psimd_pkg.sv
// psimd_pkg: shared defaults and word type for the PSIMD register file slice.
package psimd_pkg;
   localparam int DEF_XLEN  = 64;
   localparam int DEF_NREGS = 32;
   typedef logic [DEF_XLEN-1:0] xword_t;
endpackage

// File: rtl/psimd_scoreboard.sv
// psimd_scoreboard: per-register busy bits, issue acceptance and sticky pair-OOB flag.
module psimd_scoreboard
   import psimd_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic [AW-1:0]    issue_rd,
   input  logic             issue_pair,
   output logic             issue_ready,
   input  logic [NREGS-1:0] clr_vec,
   input  logic             wb_oob,
   output logic [NREGS-1:0] busy_vec,
   output logic             err_pair_oob
);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
   logic [AW-1:0]    issue_nxt;
   logic             issue_oob;
   logic             accept;
   logic [NREGS-1:0] set_vec;
   assign issue_nxt   = AW'(issue_rd + 1);
   assign issue_oob   = issue_pair && issue_rd == LAST;
   assign issue_ready = !busy_vec[issue_rd] && !(issue_pair && (issue_oob || busy_vec[issue_nxt]));
   assign accept      = issue_valid && issue_ready;
   always_comb begin
      set_vec = '0;
      set_vec[issue_rd] = accept;
      if (accept && issue_pair) set_vec[issue_nxt] = 1'b1;
   end
   // set is OR'ed after the clear so a same-cycle issue keeps the register busy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_vec     <= '0;
         err_pair_oob <= 1'b0;
      end else begin
         busy_vec     <= (busy_vec & ~clr_vec) | set_vec;
         err_pair_oob <= err_pair_oob | wb_oob | (issue_valid && issue_oob);
      end
   end
endmodule

// File: rtl/psimd_vreg_file.sv
// psimd_vreg_file: register array with single and pair writeback ports, write-first
// read bypass, and an issue-side scoreboard.
module psimd_vreg_file
   import psimd_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREGS = DEF_NREGS,
   parameter int NRD   = 3,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NRD-1:0][AW-1:0]   rd_addr,
   output logic [NRD-1:0][XLEN-1:0] rd_data,
   output logic [NRD-1:0]           rd_busy,
   input  logic                     issue_valid,
   input  logic [AW-1:0]            issue_rd,
   input  logic                     issue_pair,
   output logic                     issue_ready,
   input  logic                     wa_en,
   input  logic [AW-1:0]            wa_addr,
   input  logic [XLEN-1:0]          wa_data,
   input  logic                     wb_en,
   input  logic                     wb_pair,
   input  logic [AW-1:0]            wb_addr,
   input  logic [XLEN-1:0]          wb_data0,
   input  logic [XLEN-1:0]          wb_data1,
   output logic [NREGS-1:0]         busy_vec,
   output logic                     err_pair_oob
);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
   logic [XLEN-1:0]  mem [NREGS];
   logic [AW-1:0]    wb_nxt;
   logic             wb_hi;
   logic             wb_oob;
   logic [NREGS-1:0] clr_vec;
   assign wb_nxt = AW'(wb_addr + 1);
   assign wb_hi  = wb_en && wb_pair && wb_addr != LAST;
   assign wb_oob = wb_en && wb_pair && wb_addr == LAST;
   // pair-port writes come last so they override wa on the same register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) mem[r] <= '0;
      end else begin
         if (wa_en) mem[wa_addr] <= wa_data;
         if (wb_en) mem[wb_addr] <= wb_data0;
         if (wb_hi) mem[wb_nxt] <= wb_data1;
      end
   end
   always_comb begin
      for (int i = 0; i < NRD; i++) begin
         rd_data[i] = (wb_hi && wb_nxt == rd_addr[i]) ? wb_data1 :
                      (wb_en && wb_addr == rd_addr[i]) ? wb_data0 :
                      (wa_en && wa_addr == rd_addr[i]) ? wa_data : mem[rd_addr[i]];
         rd_busy[i] = busy_vec[rd_addr[i]];
      end
   end
   always_comb begin
      clr_vec = '0;
      if (wa_en) clr_vec[wa_addr] = 1'b1;
      if (wb_en) clr_vec[wb_addr] = 1'b1;
      if (wb_hi) clr_vec[wb_nxt] = 1'b1;
   end
   psimd_scoreboard #(.NREGS(NREGS)) u_sb (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .issue_pair   (issue_pair),
      .issue_ready  (issue_ready),
      .clr_vec      (clr_vec),
      .wb_oob       (wb_oob),
      .busy_vec     (busy_vec),
      .err_pair_oob (err_pair_oob)
   );
endmodule

// File: tb/tb_psimd_vreg_file.sv
// tb_psimd_vreg_file: directed vectors with hand-computed expectations for psimd_vreg_file.
module tb_psimd_vreg_file;
   import psimd_pkg::*;
   logic clk = 1'b0;
   logic rst_n;
   logic [2:0][4:0]  rd_addr;
   logic [2:0][63:0] rd_data;
   logic [2:0]       rd_busy;
   logic issue_valid, issue_pair, issue_ready;
   logic [4:0] issue_rd;
   logic wa_en, wb_en, wb_pair;
   logic [4:0] wa_addr, wb_addr;
   xword_t wa_data, wb_data0, wb_data1;
   logic [31:0] busy_vec;
   logic err_pair_oob;
   int n_run = 0;
   int n_fail = 0;

   psimd_vreg_file dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_pair(issue_pair),
      .issue_ready(issue_ready), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_pair(wb_pair), .wb_addr(wb_addr), .wb_data0(wb_data0),
      .wb_data1(wb_data1), .busy_vec(busy_vec), .err_pair_oob(err_pair_oob)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; issue_pair = 0; wa_en = 0; wb_en = 0; wb_pair = 0;
   endtask

   initial begin
      rst_n = 0; idle(); issue_rd = 0; wa_addr = 0; wb_addr = 0;
      wa_data = 0; wb_data0 = 0; wb_data1 = 0;
      rd_addr[0] = 5'd0; rd_addr[1] = 5'd5; rd_addr[2] = 5'd31;
      tick(); tick();
      rst_n = 1;
      #1;
      chk("rst_r0", rd_data[0], 64'd0);
      chk("rst_r5", rd_data[1], 64'd0);
      chk("rst_r31", rd_data[2], 64'd0);
      chk("rst_busy", busy_vec, 64'd0);
      chk("rst_rdbusy", rd_busy, 64'd0);
      chk("rst_ready", issue_ready, 64'd1);
      chk("rst_err", err_pair_oob, 64'd0);
      // pair write r4/r5, bypass of the upper half
      wb_en = 1; wb_pair = 1; wb_addr = 5'd4;
      wb_data0 = 64'hAAAA_AAAA_AAAA_AAAA; wb_data1 = 64'h5555_5555_5555_5555;
      rd_addr[0] = 5'd5; rd_addr[1] = 5'd4;
      #1;
      chk("byp_r5", rd_data[0], 64'h5555_5555_5555_5555);
      chk("byp_r4", rd_data[1], 64'hAAAA_AAAA_AAAA_AAAA);
      tick(); idle(); #1;
      chk("arr_r5", rd_data[0], 64'h5555_5555_5555_5555);
      chk("arr_r4", rd_data[1], 64'hAAAA_AAAA_AAAA_AAAA);
      // wa vs pair port on r7
      wa_en = 1; wa_addr = 5'd7; wa_data = 64'h1;
      wb_en = 1; wb_pair = 1; wb_addr = 5'd6; wb_data0 = 64'h2; wb_data1 = 64'h3;
      rd_addr[0] = 5'd7; rd_addr[1] = 5'd6;
      #1;
      chk("cfl_byp_r7", rd_data[0], 64'h3);
      chk("cfl_byp_r6", rd_data[1], 64'h2);
      tick(); idle(); #1;
      chk("cfl_arr_r7", rd_data[0], 64'h3);
      chk("cfl_arr_r6", rd_data[1], 64'h2);
      // scoreboard
      issue_valid = 1; issue_rd = 5'd10; issue_pair = 1;
      #1;
      chk("iss10_ready", issue_ready, 64'd1);
      tick(); idle(); rd_addr[2] = 5'd11; #1;
      chk("busy10", busy_vec[10], 64'd1);
      chk("busy11", busy_vec[11], 64'd1);
      chk("rdbusy11", rd_busy[2], 64'd1);
      issue_valid = 1; issue_rd = 5'd11; issue_pair = 0;
      #1;
      chk("iss11_blocked", issue_ready, 64'd0);
      issue_valid = 0;
      wa_en = 1; wa_addr = 5'd11; wa_data = 64'h11; rd_addr[0] = 5'd11;
      #1;
      chk("wb11_rdbusy_same", rd_busy[0], 64'd1);
      chk("wb11_byp", rd_data[0], 64'h11);
      chk("wb11_ready_same", issue_ready, 64'd0);
      tick(); idle(); #1;
      chk("busy11_clr", busy_vec[11], 64'd0);
      chk("busy10_kept", busy_vec[10], 64'd1);
      // issue and writeback to r11 together: set wins
      issue_valid = 1; issue_rd = 5'd11; issue_pair = 0;
      wa_en = 1; wa_addr = 5'd11; wa_data = 64'h22;
      #1;
      chk("iss11_ready", issue_ready, 64'd1);
      tick(); idle(); #1;
      chk("busy11_setwins", busy_vec[11], 64'd1);
      // non-pair write on pair port only touches wb_addr
      wb_en = 1; wb_pair = 0; wb_addr = 5'd10; wb_data0 = 64'h10; wb_data1 = 64'hBAD;
      tick(); idle(); rd_addr[0] = 5'd10; rd_addr[1] = 5'd11; #1;
      chk("busy10_clr", busy_vec[10], 64'd0);
      chk("np_r10", rd_data[0], 64'h10);
      chk("np_r11", rd_data[1], 64'h22);
      // boundary: pair write at r31
      wa_en = 1; wa_addr = 5'd0; wa_data = 64'h77;
      tick(); idle();
      wb_en = 1; wb_pair = 1; wb_addr = 5'd31; wb_data0 = 64'hF0F0; wb_data1 = 64'hDEAD;
      rd_addr[0] = 5'd0; rd_addr[1] = 5'd31;
      #1;
      chk("oob_r0_byp", rd_data[0], 64'h77);
      chk("oob_err_pre", err_pair_oob, 64'd0);
      tick(); idle(); #1;
      chk("oob_r31", rd_data[1], 64'hF0F0);
      chk("oob_r0", rd_data[0], 64'h77);
      chk("oob_err", err_pair_oob, 64'd1);
      issue_rd = 5'd31; issue_pair = 1;
      #1;
      chk("iss31_pair_ready", issue_ready, 64'd0);
      tick(); tick(); #1;
      chk("oob_err_sticky", err_pair_oob, 64'd1);
      // mid-operation reset with pending write and issue
      wa_en = 1; wa_addr = 5'd3; wa_data = 64'h99;
      issue_valid = 1; issue_rd = 5'd20; issue_pair = 0;
      rst_n = 0;
      tick(); rst_n = 1; idle(); rd_addr[0] = 5'd3; rd_addr[1] = 5'd31; rd_addr[2] = 5'd4; #1;
      chk("mrst_busy", busy_vec, 64'd0);
      chk("mrst_err", err_pair_oob, 64'd0);
      chk("mrst_r3", rd_data[0], 64'd0);
      chk("mrst_r31", rd_data[1], 64'd0);
      chk("mrst_r4", rd_data[2], 64'd0);
      chk("mrst_ready", issue_ready, 64'd1);
      // rejected pair issue at r31 still flags the error
      issue_valid = 1; issue_rd = 5'd31; issue_pair = 1;
      tick(); idle(); #1;
      chk("iss_oob_err", err_pair_oob, 64'd1);
      chk("iss_oob_busy", busy_vec, 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
